// File: rtl/axis_cnt_seq.sv
// Burst sequencer for an AXI-Stream counter source.
// Runs a configured number of bursts with optional idle gaps, abortable by stop_i.
module axis_cnt_seq #(
    parameter int TDATA_DW = 32,
    parameter int BURST_DW = 16,
    parameter int GAP_DW   = 16
) (
    input  logic                m_axis_aclk,
    input  logic                m_axis_aresetn,
    input  logic [TDATA_DW-1:0] max_value_i,
    input  logic [BURST_DW-1:0] burst_qty_i,
    input  logic [GAP_DW-1:0]   gap_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                mon_tvalid_i,
    input  logic                mon_tready_i,
    input  logic                mon_tlast_i,
    output logic [TDATA_DW-1:0] max_value_o,
    output logic                cnt_en_o,
    output logic                cnt_single_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                stopped_o,
    output logic [BURST_DW-1:0] burst_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [BURST_DW-1:0] B_ONE = 1;
    localparam logic [GAP_DW-1:0]   G_ONE = 1;

    state_t              state_q, state_d;
    logic [BURST_DW-1:0] qty_q, qty_d;
    logic [BURST_DW-1:0] bcnt_d;
    logic [GAP_DW-1:0]   gap_q, gap_d;
    logic [GAP_DW-1:0]   gcnt_q, gcnt_d;
    logic [TDATA_DW-1:0] max_d;
    logic                pend_q, pend_d;
    logic                stopped_d;
    logic                cnt_en_d, cnt_single_d;
    logic                busy_d, done_d;
    logic                eob;

    // Final burst: a non-zero quantity with qty-1 bursts already completed
    function automatic logic is_last(input logic [BURST_DW-1:0] q,
                                     input logic [BURST_DW-1:0] c);
        return (q != '0) && (c >= q - B_ONE);
    endfunction

    assign eob = mon_tvalid_i & mon_tready_i & mon_tlast_i;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state_q      <= S_IDLE;
            qty_q        <= '0;
            gap_q        <= '0;
            gcnt_q       <= '0;
            pend_q       <= 1'b0;
            max_value_o  <= '0;
            burst_cnt_o  <= '0;
            stopped_o    <= 1'b0;
            cnt_en_o     <= 1'b0;
            cnt_single_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            qty_q        <= qty_d;
            gap_q        <= gap_d;
            gcnt_q       <= gcnt_d;
            pend_q       <= pend_d;
            max_value_o  <= max_d;
            burst_cnt_o  <= bcnt_d;
            stopped_o    <= stopped_d;
            cnt_en_o     <= cnt_en_d;
            cnt_single_o <= cnt_single_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        qty_d     = qty_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        pend_d    = pend_q;
        max_d     = max_value_o;
        bcnt_d    = burst_cnt_o;
        stopped_d = stopped_o;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    max_d     = max_value_i;
                    qty_d     = burst_qty_i;
                    gap_d     = gap_i;
                    bcnt_d    = '0;
                    stopped_d = 1'b0;
                    pend_d    = 1'b0;
                end
            end
            S_RUN: begin
                if (stop_i) pend_d = 1'b1;
                if (eob) begin
                    bcnt_d = (burst_cnt_o == '1) ? burst_cnt_o
                                                 : burst_cnt_o + B_ONE;
                    gcnt_d = '0;
                    if (is_last(qty_q, burst_cnt_o) || pend_q || stop_i) begin
                        state_d   = S_DONE;
                        stopped_d = pend_q | stop_i;
                    end else if (gap_q != '0) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (stop_i) begin
                    state_d   = S_DONE;
                    stopped_d = 1'b1;
                end else if (gcnt_q == gap_q - G_ONE) begin
                    state_d = S_RUN;
                end else begin
                    gcnt_d = gcnt_q + G_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controls are computed from next-state values so the outputs are flops
    always_comb begin
        cnt_single_d = (state_d == S_RUN);
        cnt_en_d     = cnt_single_d && (gap_d == '0) && !pend_d &&
                       !is_last(qty_d, bcnt_d);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

endmodule
